multi_channel_timer: RTL and testbench
======================================

# multi_channel_timer

Parametrised successor to the single-channel digital timer: NUM_CH independent down-counting timers of WIDTH bits sharing one configuration port, each runnable one-shot or periodic. Each channel raises a one-cycle `expired` pulse and a sticky `pending` flag that software clears. It sits beside the core as the platform timer / interrupt source. Its one-shot timing is cycle-identical to the legacy timer: expiry is visible exactly N cycles after the load.

## Interface
- NUM_CH, default 4: number of channels, 1..32.
- WIDTH, default 32: counter width in bits, 2..32.
- CH_W, derived: $clog2(NUM_CH), minimum 1.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  configuration write strobe, sampled at rising edge.
- cfg_ch  in  CH_W  channel targeted by cfg_we; out-of-range index ignored.
- cfg_load  in  WIDTH  reload/period value N.
- cfg_periodic  in  1  1 = periodic mode, 0 = one-shot.
- stop  in  NUM_CH  per-channel cancel; returns channel to IDLE.
- irq_clr  in  NUM_CH  write-1-to-clear for `pending`.
- rd_ch  in  CH_W  channel selected for count readback.
- rd_count  out  WIDTH  combinational current counter of channel rd_ch.
- expired  out  NUM_CH  one-cycle pulse per expiry, registered.
- pending  out  NUM_CH  sticky expiry flag.
- active  out  NUM_CH  channel state is not IDLE.
- irq  out  1  OR-reduction of `pending`.

## Operation
- Per-channel state: IDLE, RUN_ONESHOT, RUN_PERIODIC; also a WIDTH-bit counter `cnt` and a WIDTH-bit reload register `rld`.
- Write with N ≥ 1 (cfg_we, cfg_ch = c): cnt ← N, rld ← N, state ← RUN_PERIODIC if cfg_periodic else RUN_ONESHOT. A write while the channel is running restarts it.
- Write with N = 0: state ← IDLE, cnt ← 0. No expiry is ever produced.
- Running, cnt > 1: cnt decrements by 1 per edge.
- Running, cnt == 1 at an edge: expired[c] ← 1 for the following cycle, pending[c] ← 1.
  - One-shot: cnt ← 0, state ← IDLE.
  - Periodic: cnt ← rld.
- No wrap-around: the counter never decrements below 0. Arithmetic is unsigned WIDTH bits; all-ones is a legal period.
- stop[c]: state ← IDLE, cnt ← 0. Does not affect `pending`.
- Priority per channel at one edge, highest first:
  1. cfg_we to c. An expiry due at the same edge is suppressed: no expired, no pending set.
  2. stop[c]. Also suppresses a coincident expiry.
  3. Normal count/expiry.
- irq_clr[c] coinciding with a new expiry on c: the set wins and pending stays 1.
- cfg_we never clears `pending`.
- Reset (asynchronous, any time, including mid-count): all channels IDLE. cnt, rld, expired, pending, active and irq are all 0; rd_count reads 0.

## Timing
- Load of N sampled at edge E0:
  - expired is 0 during cycles E0+1 .. E0+N−1.
  - expired is 1 in the cycle after edge E0+N.
  - pending is 1 from edge E0+N onward.
- Periodic mode: subsequent expiries at edges E0+kN.
  - N = 1 gives expired high every cycle.
- active goes 1 the cycle after the load edge. In one-shot mode it goes 0 the same cycle expired goes 1.
- irq is combinational from the pending register (no added latency).
- rd_count shows the post-edge counter value; zero-latency read.

## Structure
- Package `timer_pkg`:
  - typedef enum logic [1:0] tmr_state_e {TMR_IDLE, TMR_ONESHOT, TMR_PERIODIC}.
  - Parameter bounds constants.
- Sub-module `timer_channel` (WIDTH parameter): one state machine plus counter and reload register. Top level generates NUM_CH instances, decodes cfg_ch into per-channel write enables, muxes rd_count, and ORs irq.

## Test plan
- Reset, load ch0 N=5 one-shot → expired[0] 0 for cycles 1–4, pulse at cycle 5; pending[0]=1; active[0]=0 afterward; irq=1.
- ch1 N=3 periodic for 10 cycles → expired[1] pulses at cycles 3, 6, 9; irq_clr[1] at cycle 7 → pending 0 until cycle 9.
- ch2 N=4 and ch3 N=4 loaded together, stop[3] at cycle 2 → only ch2 expires at cycle 4; active[3]=0 from cycle 3.
- ch0 N=2 with a rewrite N=6 at the expiry edge → no pulse at 2; pulse at 2+6=8. irq_clr coincident with an expiry → pending stays 1.
- N=0 write, then N=1 periodic → no expiry for N=0; expired every cycle after. Reset asserted mid-count → all outputs 0 immediately.
- WIDTH=4, N=4'hF → expiry at exactly cycle 15, no wrap; sweep N=1..200 on every channel against a reference model.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and parameter bounds for the multi-channel platform timer.
// Channel states, plus the legal ranges for NUM_CH and WIDTH.
package timer_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE     = 2'd0,
    TMR_ONESHOT  = 2'd1,
    TMR_PERIODIC = 2'd2
  } tmr_state_e;

  localparam int MIN_CH    = 1;
  localparam int MAX_CH    = 32;
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: IDLE / one-shot / periodic, expiry one N-cycle count after load.
// expired is a registered pulse one cycle after the expiry edge; pending is sticky until irq_clr.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_load,
  input  logic             i_periodic,
  input  logic             i_stop,
  input  logic             i_irq_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_expired,
  output logic             o_pending,
  output logic             o_active
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  tmr_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_rld, w_rld_nxt;
  logic             r_expired, r_pending;
  logic             w_fire;

  // A config write or stop at the same edge pre-empts any expiry that was due.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rld_nxt   = r_rld;
    w_fire      = 1'b0;
    if (i_we) begin
      if (i_load != '0) begin
        w_cnt_nxt   = i_load;
        w_rld_nxt   = i_load;
        w_state_nxt = i_periodic ? TMR_PERIODIC : TMR_ONESHOT;
      end else begin
        w_cnt_nxt   = '0;
        w_state_nxt = TMR_IDLE;
      end
    end else if (i_stop) begin
      w_cnt_nxt   = '0;
      w_state_nxt = TMR_IDLE;
    end else if (r_state != TMR_IDLE) begin
      if (r_cnt == ONE) begin
        w_fire = 1'b1;
        if (r_state == TMR_PERIODIC) begin
          w_cnt_nxt = r_rld;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = TMR_IDLE;
        end
      end else if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= TMR_IDLE;
      r_cnt     <= '0;
      r_rld     <= '0;
      r_expired <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rld     <= w_rld_nxt;
      r_expired <= w_fire;
      r_pending <= w_fire | (r_pending & ~i_irq_clr);
    end
  end

  assign o_count   = r_cnt;
  assign o_expired = r_expired;
  assign o_pending = r_pending;
  assign o_active  = (r_state != TMR_IDLE);

endmodule

// File: rtl/multi_channel_timer.sv
// NUM_CH independent timers behind one config port; zero-latency count readback, irq = OR of pending.
// Expiry visible exactly N cycles after the load edge; no flow control, every write takes effect.
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_load,
  input  logic              cfg_periodic,
  input  logic [NUM_CH-1:0] stop,
  input  logic [NUM_CH-1:0] irq_clr,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [WIDTH-1:0]  rd_count,
  output logic [NUM_CH-1:0] expired,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] active,
  output logic              irq
);

  if (NUM_CH < MIN_CH || NUM_CH > MAX_CH || WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_param
    $error("multi_channel_timer: NUM_CH or WIDTH out of range");
  end

  logic [NUM_CH-1:0] w_we;
  logic [WIDTH-1:0]  w_cnt [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Indices at or beyond NUM_CH match no channel, so such writes are dropped.
    assign w_we[c] = cfg_we & (cfg_ch == CH_W'(c));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_we       (w_we[c]),
      .i_load     (cfg_load),
      .i_periodic (cfg_periodic),
      .i_stop     (stop[c]),
      .i_irq_clr  (irq_clr[c]),
      .o_count    (w_cnt[c]),
      .o_expired  (expired[c]),
      .o_pending  (pending[c]),
      .o_active   (active[c])
    );
  end

  always_comb begin
    rd_count = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) rd_count = w_cnt[c];
    end
  end

  assign irq = |pending;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer: a 4x32 instance for most scenarios, a 2x4 one for the all-ones period.
module tb_multi_channel_timer;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cfg_we = 1'b0;
  logic [CW-1:0]  cfg_ch = '0;
  logic [W-1:0]   cfg_load = '0;
  logic           cfg_periodic = 1'b0;
  logic [NCH-1:0] stop = '0;
  logic [NCH-1:0] irq_clr = '0;
  logic [CW-1:0]  rd_ch = '0;
  logic [W-1:0]   rd_count;
  logic [NCH-1:0] expired, pending, active;
  logic           irq;

  logic       w4_we = 1'b0;
  logic [0:0] w4_ch = '0;
  logic [3:0] w4_load = '0;
  logic       w4_per = 1'b0;
  logic [1:0] w4_stop = '0;
  logic [1:0] w4_clr = '0;
  logic [0:0] w4_rd = '0;
  logic [3:0] w4_count;
  logic [1:0] w4_expired, w4_pending, w4_active;
  logic       w4_irq;

  int n_tests = 0;
  int n_fail  = 0;

  multi_channel_timer #(.NUM_CH(NCH), .WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_load(cfg_load),
    .cfg_periodic(cfg_periodic), .stop(stop), .irq_clr(irq_clr), .rd_ch(rd_ch),
    .rd_count(rd_count), .expired(expired), .pending(pending), .active(active), .irq(irq)
  );

  multi_channel_timer #(.NUM_CH(2), .WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .cfg_we(w4_we), .cfg_ch(w4_ch), .cfg_load(w4_load),
    .cfg_periodic(w4_per), .stop(w4_stop), .irq_clr(w4_clr), .rd_ch(w4_rd),
    .rd_count(w4_count), .expired(w4_expired), .pending(w4_pending), .active(w4_active), .irq(w4_irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input logic [W-1:0] n, input logic per);
    cfg_we       = 1'b1;
    cfg_ch       = ch[CW-1:0];
    cfg_load     = n;
    cfg_periodic = per;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    n_tests++; if (expired !== 4'b0) begin n_fail++; $display("FAIL reset_expired: got %b expected 0000", expired); end
    n_tests++; if (pending !== 4'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0000", pending); end
    n_tests++; if (active !== 4'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0000", active); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_tests++; if (rd_count !== 32'd0) begin n_fail++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
    n_tests++; if (w4_active !== 2'b0 || w4_count !== 4'd0) begin n_fail++; $display("FAIL reset_w4: got active %b count %0d expected 00 / 0", w4_active, w4_count); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_oneshot;
    logic [NCH-1:0] e;
    rd_ch = 2'd0;
    load(0, 32'd5, 1'b0);
    tick();
    cfg_we = 1'b0;
    n_tests++; if (active !== 4'b0001) begin n_fail++; $display("FAIL oneshot_active_start: got %b expected 0001", active); end
    n_tests++; if (rd_count !== 32'd5) begin n_fail++; $display("FAIL oneshot_count_start: got %0d expected 5", rd_count); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      e = (k == 5) ? 4'b0001 : 4'b0000;
      n_tests++; if (expired !== e) begin n_fail++; $display("FAIL oneshot_expired k=%0d: got %b expected %b", k, expired, e); end
      n_tests++; if (rd_count !== W'(5 - k)) begin n_fail++; $display("FAIL oneshot_count k=%0d: got %0d expected %0d", k, rd_count, 5 - k); end
    end
    n_tests++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL oneshot_pending: got %b expected 0001", pending); end
    n_tests++; if (active !== 4'b0000) begin n_fail++; $display("FAIL oneshot_active_end: got %b expected 0000", active); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq: got %b expected 1", irq); end
    irq_clr = 4'b0001;
    tick();
    irq_clr = 4'b0000;
    n_tests++; if (pending !== 4'b0000 || irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_clear: got pending %b irq %b expected 0000 / 0", pending, irq); end
    n_tests++; if (expired !== 4'b0000) begin n_fail++; $display("FAIL oneshot_no_repeat: got %b expected 0000", expired); end
  endtask

  task automatic test_periodic;
    logic [NCH-1:0] e, p;
    load(1, 32'd3, 1'b1);
    tick();
    cfg_we = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      irq_clr = (k == 7) ? 4'b0010 : 4'b0000;
      tick();
      e = (k % 3 == 0) ? 4'b0010 : 4'b0000;
      p = ((k >= 3 && k < 7) || k >= 9) ? 4'b0010 : 4'b0000;
      n_tests++; if (expired !== e) begin n_fail++; $display("FAIL periodic_expired k=%0d: got %b expected %b", k, expired, e); end
      n_tests++; if (pending !== p) begin n_fail++; $display("FAIL periodic_pending k=%0d: got %b expected %b", k, pending, p); end
    end
    irq_clr = 4'b0000;
    stop = 4'b0010;
    tick();
    stop = 4'b0000;
    n_tests++; if (active !== 4'b0000) begin n_fail++; $display("FAIL periodic_stop_active: got %b expected 0000", active); end
    n_tests++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL periodic_stop_keeps_pending: got %b expected 0010", pending); end
    irq_clr = 4'b0010;
    tick();
    irq_clr = 4'b0000;
  endtask

  task automatic test_stop;
    logic [NCH-1:0] e, a;
    load(2, 32'd4, 1'b0);
    tick();
    load(3, 32'd4, 1'b0);
    tick();
    cfg_we = 1'b0;
    n_tests++; if (active !== 4'b1100) begin n_fail++; $display("FAIL stop_active_start: got %b expected 1100", active); end
    for (int k = 2; k <= 7; k++) begin
      stop = (k == 2) ? 4'b1000 : 4'b0000;
      tick();
      e = (k == 4) ? 4'b0100 : 4'b0000;
      a = (k < 4) ? 4'b0100 : 4'b0000;
      n_tests++; if (expired !== e) begin n_fail++; $display("FAIL stop_expired k=%0d: got %b expected %b", k, expired, e); end
      n_tests++; if (active !== a) begin n_fail++; $display("FAIL stop_active k=%0d: got %b expected %b", k, active, a); end
    end
    stop = 4'b0000;
    n_tests++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL stop_pending: got %b expected 0100", pending); end
    irq_clr = 4'b0100;
    tick();
    irq_clr = 4'b0000;
  endtask

  task automatic test_rewrite;
    logic [NCH-1:0] e;
    load(0, 32'd2, 1'b0);
    tick();
    cfg_we = 1'b0;
    tick();
    n_tests++; if (expired !== 4'b0000) begin n_fail++; $display("FAIL rewrite_k1: got %b expected 0000", expired); end
    load(0, 32'd6, 1'b0);
    tick();
    cfg_we = 1'b0;
    n_tests++; if (expired !== 4'b0000) begin n_fail++; $display("FAIL rewrite_suppressed: got %b expected 0000", expired); end
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL rewrite_no_pending: got %b expected 0000", pending); end
    for (int k = 3; k <= 8; k++) begin
      tick();
      e = (k == 8) ? 4'b0001 : 4'b0000;
      n_tests++; if (expired !== e) begin n_fail++; $display("FAIL rewrite_expired k=%0d: got %b expected %b", k, expired, e); end
    end
    load(0, 32'd2, 1'b1);
    tick();
    cfg_we = 1'b0;
    n_tests++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL write_keeps_pending: got %b expected 0001", pending); end
    tick();
    irq_clr = 4'b0001;
    tick();
    irq_clr = 4'b0000;
    n_tests++; if (expired !== 4'b0001) begin n_fail++; $display("FAIL clr_coincident_expired: got %b expected 0001", expired); end
    n_tests++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL clr_coincident_pending: got %b expected 0001", pending); end
    irq_clr = 4'b0001;
    tick();
    irq_clr = 4'b0000;
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL clr_plain: got %b expected 0000", pending); end
    stop = 4'b0001;
    tick();
    stop = 4'b0000;
    n_tests++; if (active !== 4'b0000) begin n_fail++; $display("FAIL rewrite_stop_active: got %b expected 0000", active); end
  endtask

  task automatic test_zero_then_one;
    rd_ch = 2'd1;
    load(1, 32'd0, 1'b1);
    tick();
    cfg_we = 1'b0;
    n_tests++; if (active !== 4'b0000 || rd_count !== 32'd0) begin n_fail++; $display("FAIL zero_load: got active %b count %0d expected 0000 / 0", active, rd_count); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_tests++; if (expired !== 4'b0000 || pending !== 4'b0000) begin n_fail++; $display("FAIL zero_no_expiry k=%0d: got expired %b pending %b expected 0000", k, expired, pending); end
    end
    load(1, 32'd1, 1'b1);
    tick();
    cfg_we = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_tests++; if (expired !== 4'b0010) begin n_fail++; $display("FAIL n1_every_cycle k=%0d: got %b expected 0010", k, expired); end
      n_tests++; if (rd_count !== 32'd1) begin n_fail++; $display("FAIL n1_count k=%0d: got %0d expected 1", k, rd_count); end
    end
  endtask

  task automatic test_reset_mid;
    load(0, 32'd10, 1'b0);
    tick();
    cfg_we = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if (expired !== 4'b0 || pending !== 4'b0 || active !== 4'b0) begin n_fail++; $display("FAIL reset_mid_outputs: got expired %b pending %b active %b expected all 0", expired, pending, active); end
    n_tests++; if (irq !== 1'b0 || rd_count !== 32'd0) begin n_fail++; $display("FAIL reset_mid_irq_count: got irq %b count %0d expected 0 / 0", irq, rd_count); end
    tick();
    rst = 1'b1;
    tick();
    n_tests++; if (active !== 4'b0 || expired !== 4'b0) begin n_fail++; $display("FAIL reset_mid_after: got active %b expired %b expected 0000", active, expired); end
  endtask

  task automatic test_width4;
    logic [1:0] e;
    logic [3:0] c;
    w4_we = 1'b1; w4_ch = 1'b0; w4_load = 4'hF; w4_per = 1'b0; w4_rd = 1'b0;
    tick();
    w4_we = 1'b0;
    n_tests++; if (w4_count !== 4'd15) begin n_fail++; $display("FAIL w4_count_start: got %0d expected 15", w4_count); end
    for (int k = 1; k <= 17; k++) begin
      tick();
      e = (k == 15) ? 2'b01 : 2'b00;
      c = (k < 15) ? 4'(15 - k) : 4'd0;
      n_tests++; if (w4_expired !== e) begin n_fail++; $display("FAIL w4_expired k=%0d: got %b expected %b", k, w4_expired, e); end
      n_tests++; if (w4_count !== c) begin n_fail++; $display("FAIL w4_count k=%0d: got %0d expected %0d", k, w4_count, c); end
    end
    n_tests++; if (w4_pending !== 2'b01 || w4_active !== 2'b00 || w4_irq !== 1'b1) begin n_fail++; $display("FAIL w4_end: got pending %b active %b irq %b expected 01 / 00 / 1", w4_pending, w4_active, w4_irq); end
  endtask

  task automatic test_sweep;
    logic [NCH-1:0] e;
    for (int n = 1; n <= 200; n++) begin
      for (int k = 0; k <= n + 4; k++) begin
        if (k < NCH) load(k, W'(n), 1'b0);
        else cfg_we = 1'b0;
        tick();
        if (k >= 1) begin
          for (int c = 0; c < NCH; c++) e[c] = (k == c + n);
          n_tests++; if (expired !== e) begin n_fail++; $display("FAIL sweep n=%0d k=%0d: got %b expected %b", n, k, expired, e); end
        end
      end
      cfg_we = 1'b0;
      n_tests++; if (pending !== 4'b1111 || active !== 4'b0000) begin n_fail++; $display("FAIL sweep_end n=%0d: got pending %b active %b expected 1111 / 0000", n, pending, active); end
      irq_clr = 4'b1111;
      tick();
      irq_clr = 4'b0000;
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_stop();
    test_rewrite();
    test_zero_then_one();
    test_reset_mid();
    test_width4();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
